// File: rtl/sw_wavefront_sched.sv
// Anti-diagonal wavefront scheduler: walks a rows x cols matrix diagonal by diagonal,
// issuing LANES-wide chunks and waiting for every chunk of a diagonal to retire before the next.
module sw_wavefront_sched #(
    parameter int unsigned MAX_DIM = 12,
    parameter int unsigned DIM_W   = 4,
    parameter int unsigned DIAG_W  = 5,
    parameter int unsigned LANES   = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  rows_i,
    input  logic [DIM_W-1:0]  cols_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output logic [DIAG_W-1:0] issue_diag_o,
    output logic [DIM_W-1:0]  issue_row_o,
    output logic [DIM_W-1:0]  issue_col_o,
    output logic [LANES-1:0]  issue_mask_o,
    input  logic              retire_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic [CNT_W-1:0]  cycles_o
);

    localparam int unsigned OUT_W = $clog2(2 * MAX_DIM + 1);
    localparam int unsigned REM_W = DIM_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DIM_W-1:0]  r_rows, w_rows_nxt;
    logic [DIM_W-1:0]  r_cols, w_cols_nxt;
    logic [DIM_W-1:0]  r_row, w_row_nxt;
    logic [DIM_W-1:0]  r_col, w_col_nxt;
    logic [DIM_W-1:0]  r_rmax, w_rmax_nxt;
    logic [DIAG_W-1:0] r_diag, w_diag_nxt;
    logic [LANES-1:0]  r_mask, w_mask_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_cfg_err, w_cfg_err_nxt;
    logic [OUT_W-1:0]  r_out, w_out_nxt;
    logic [CNT_W-1:0]  r_cycles, w_cycles_nxt;

    logic              w_fire;
    logic              w_cfg_ok;
    logic              w_last_chunk;
    logic [DIM_W-1:0]  w_row_step;
    logic [DIAG_W-1:0] w_last_diag;
    logic [DIAG_W-1:0] w_d1;
    logic [DIM_W-1:0]  w_rmin_d1;
    logic [DIM_W-1:0]  w_rmax_d1;

    // Lane mask with min(LANES, rmax-row+1) low bits set
    function automatic logic [LANES-1:0] f_mask(input logic [DIM_W-1:0] row,
                                                 input logic [DIM_W-1:0] rmax);
        logic [REM_W-1:0] rem;
        logic [LANES-1:0] m;
        m   = '0;
        rem = REM_W'(rmax) - REM_W'(row) + REM_W'(1);
        for (int k = 0; k < int'(LANES); k++) begin
            m[k] = (REM_W'(k) < rem);
        end
        return m;
    endfunction

    assign w_fire       = r_valid & issue_ready_i;
    assign w_cfg_ok     = (rows_i != '0) && (rows_i <= DIM_W'(MAX_DIM)) &&
                          (cols_i != '0) && (cols_i <= DIM_W'(MAX_DIM));
    assign w_last_chunk = (REM_W'(r_rmax) - REM_W'(r_row)) < REM_W'(LANES);
    assign w_row_step   = r_row + DIM_W'(LANES);
    assign w_last_diag  = DIAG_W'(r_rows) + DIAG_W'(r_cols) - DIAG_W'(2);

    // Row span of the following diagonal
    assign w_d1      = r_diag + DIAG_W'(1);
    assign w_rmin_d1 = (w_d1 >= DIAG_W'(r_cols)) ?
                       DIM_W'(w_d1 - DIAG_W'(r_cols) + DIAG_W'(1)) : '0;
    assign w_rmax_d1 = (w_d1 < DIAG_W'(r_rows)) ? DIM_W'(w_d1) : r_rows - DIM_W'(1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_rows    <= '0;
            r_cols    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_rmax    <= '0;
            r_diag    <= '0;
            r_mask    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_out     <= '0;
            r_cycles  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rows    <= w_rows_nxt;
            r_cols    <= w_cols_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_rmax    <= w_rmax_nxt;
            r_diag    <= w_diag_nxt;
            r_mask    <= w_mask_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_out     <= w_out_nxt;
            r_cycles  <= w_cycles_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rows_nxt    = r_rows;
        w_cols_nxt    = r_cols;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_rmax_nxt    = r_rmax;
        w_diag_nxt    = r_diag;
        w_mask_nxt    = r_mask;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_cfg_err_nxt = 1'b0;
        w_cycles_nxt  = r_busy ? r_cycles + CNT_W'(1) : r_cycles;

        // Outstanding chunks: saturating up/down counter
        w_out_nxt = r_out;
        if (w_fire && !retire_i && (r_out != OUT_W'(2 * MAX_DIM))) begin
            w_out_nxt = r_out + OUT_W'(1);
        end else if (!w_fire && retire_i && (r_out != '0)) begin
            w_out_nxt = r_out - OUT_W'(1);
        end

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_cfg_ok) begin
                        w_state_nxt  = S_ISSUE;
                        w_rows_nxt   = rows_i;
                        w_cols_nxt   = cols_i;
                        w_diag_nxt   = '0;
                        w_row_nxt    = '0;
                        w_col_nxt    = '0;
                        w_rmax_nxt   = '0;
                        w_mask_nxt   = f_mask('0, '0);
                        w_valid_nxt  = 1'b1;
                        w_busy_nxt   = 1'b1;
                        w_cycles_nxt = '0;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (w_fire) begin
                    if (w_last_chunk) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_row_nxt  = w_row_step;
                        w_col_nxt  = DIM_W'(r_diag - DIAG_W'(w_row_step));
                        w_mask_nxt = f_mask(w_row_step, r_rmax);
                    end
                end
            end
            S_DRAIN: begin
                // Next diagonal starts once every issued chunk has retired
                if (w_out_nxt == '0) begin
                    if (r_diag == w_last_diag) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_diag_nxt  = w_d1;
                        w_row_nxt   = w_rmin_d1;
                        w_col_nxt   = DIM_W'(w_d1 - DIAG_W'(w_rmin_d1));
                        w_rmax_nxt  = w_rmax_d1;
                        w_mask_nxt  = f_mask(w_rmin_d1, w_rmax_d1);
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign issue_valid_o = r_valid;
    assign issue_diag_o  = r_diag;
    assign issue_row_o   = r_row;
    assign issue_col_o   = r_col;
    assign issue_mask_o  = r_mask;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign cfg_err_o     = r_cfg_err;
    assign cycles_o      = r_cycles;

endmodule
